// File: rtl/autoplay_pkg.sv
// Shared definitions for the autoplay note sequencer: song ROM word layout,
// the rest code and the sequencer state encoding.
package autoplay_pkg;

    localparam int NOTE_MSB = 7;
    localparam int NOTE_LSB = 3;
    localparam int DUR_MSB  = 2;
    localparam int DUR_LSB  = 0;

    localparam logic [4:0] NOTE_REST = 5'd0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_GAP   = 3'd4,
        ST_ADV   = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/autoplay_tick_gen.sv
// Timebase prescaler: counts 0..DIV-1 while enabled and pulses tick on the
// last count. A synchronous clear restarts the period.
module autoplay_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/autoplay_note_sequencer.sv
// Steps through a registered song ROM of (note, duration) words, holding each
// note for its duration, then a silent gap, and pulsing done at the end.
module autoplay_note_sequencer
    import autoplay_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int UNIT_TICKS = 125,
    parameter int GAP_TICKS  = 20,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [4:0]        note,
    output logic              playing,
    output logic              done
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DUR_W = $clog2(7 * UNIT_TICKS + 1);
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    state_t           state;
    state_t           state_next;
    logic [4:0]       note_reg;
    logic [DUR_W-1:0] dur_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             tick;
    logic             tick_en;
    logic             tick_clr;
    logic [4:0]       rom_note;
    logic [2:0]       rom_dur;
    logic             last_dur;
    logic             last_gap;

    assign rom_note = rom_data[NOTE_MSB:NOTE_LSB];
    assign rom_dur  = rom_data[DUR_MSB:DUR_LSB];
    assign last_dur = tick && (dur_cnt == DUR_W'(1));
    assign last_gap = tick && (gap_cnt == GAP_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_LOAD;
            ST_LOAD:  state_next = (rom_dur == 3'd0) ? ST_DONE : ST_PLAY;
            ST_PLAY:  if (last_dur) state_next = (GAP_TICKS > 0) ? ST_GAP : ST_ADV;
            ST_GAP:   if (last_gap) state_next = ST_ADV;
            ST_ADV:   state_next = (&rom_addr) ? ST_DONE : ST_FETCH;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (stop) state_next = ST_IDLE;
    end

    // The prescaler restarts whenever a timed state is entered.
    assign tick_en  = ((state == ST_PLAY) || (state == ST_GAP)) && !pause;
    assign tick_clr = (state_next != state) &&
                      ((state_next == ST_PLAY) || (state_next == ST_GAP));

    autoplay_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_reg <= NOTE_REST;
            rom_addr <= '0;
            dur_cnt  <= '0;
            gap_cnt  <= '0;
        end else if (stop) begin
            note_reg <= NOTE_REST;
            rom_addr <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) rom_addr <= '0;
                end
                ST_LOAD: begin
                    if (rom_dur != 3'd0) begin
                        note_reg <= rom_note;
                        dur_cnt  <= DUR_W'(rom_dur * UNIT_TICKS);
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        dur_cnt <= dur_cnt - 1'b1;
                        if (last_dur) begin
                            note_reg <= NOTE_REST;
                            gap_cnt  <= GAP_W'(GAP_TICKS);
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) gap_cnt <= gap_cnt - 1'b1;
                end
                ST_ADV: begin
                    if (!(&rom_addr)) rom_addr <= rom_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Pause silences the held note without disturbing it.
    assign note    = ((state == ST_PLAY) && pause) ? NOTE_REST : note_reg;
    assign playing = (state != ST_IDLE);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_autoplay_note_sequencer.sv
// Randomized bench for autoplay_note_sequencer: a cycle-stream model of the song
// (built from the ROM contents) is walked alongside the DUT, stretched by pause.
module tb_autoplay_note_sequencer;

    localparam int CLK_HZ     = 1000;
    localparam int TICK_HZ    = 100;
    localparam int UNIT_TICKS = 2;
    localparam int GAP_TICKS  = 1;
    localparam int ADDR_W     = 2;
    localparam int DIV        = CLK_HZ / TICK_HZ;
    localparam int GAP_CYC    = GAP_TICKS * DIV;
    localparam int ENTRIES    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              pause = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data = 8'h00;
    logic [4:0]        note;
    logic              playing;
    logic              done;

    logic [7:0] rom_mem [ENTRIES];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]        note;
        logic              playing;
        logic              done;
        logic [ADDR_W-1:0] addr;
        bit                timed;
    } item_t;

    item_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    autoplay_note_sequencer #(
        .CLK_HZ     (CLK_HZ),
        .TICK_HZ    (TICK_HZ),
        .UNIT_TICKS (UNIT_TICKS),
        .GAP_TICKS  (GAP_TICKS),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .note     (note),
        .playing  (playing),
        .done     (done)
    );

    function automatic item_t mk(logic [4:0] n, logic d, int a, bit t);
        item_t it;
        it.note    = n;
        it.playing = 1'b1;
        it.done    = d;
        it.addr    = ADDR_W'(a);
        it.timed   = t;
        return it;
    endfunction

    // Expected per-cycle observations from the start edge onwards, without pause.
    task automatic build_stream();
        logic [4:0] n;
        int         d;
        exp_q.delete();
        for (int i = 0; i < ENTRIES; i++) begin
            n = rom_mem[i][7:3];
            d = int'(rom_mem[i][2:0]);
            exp_q.push_back(mk(5'd0, 1'b0, i, 1'b0));
            exp_q.push_back(mk(5'd0, 1'b0, i, 1'b0));
            if (d == 0) begin
                exp_q.push_back(mk(5'd0, 1'b1, i, 1'b0));
                return;
            end
            for (int c = 0; c < d * UNIT_TICKS * DIV; c++) exp_q.push_back(mk(n, 1'b0, i, 1'b1));
            for (int c = 0; c < GAP_CYC; c++) exp_q.push_back(mk(5'd0, 1'b0, i, 1'b1));
            exp_q.push_back(mk(5'd0, 1'b0, i, 1'b0));
        end
        exp_q.push_back(mk(5'd0, 1'b1, ENTRIES - 1, 1'b0));
    endtask

    // Plays the loaded ROM. Pause window, stop cycle and repeat-start cycle are
    // counted in edges after the start edge (-1 disables them).
    task automatic run_song(input string name, input int p_start, input int p_len,
                            input int stop_at, input int restart_at, output int vis3);
        int                idx;
        int                post;
        bit                stopped;
        bit                finished;
        bit                chk_addr;
        item_t             it;
        logic [4:0]        en;
        logic              ep;
        logic              ed;
        logic [ADDR_W-1:0] ea;
        build_stream();
        idx = 0; post = 0; stopped = 0; finished = 0; vis3 = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int e = 0; e < 5000 && !finished; e++) begin
            pause = (e >= p_start) && (e < p_start + p_len);
            stop  = (e == stop_at);
            start = (e == restart_at);
            @(negedge clk);
            chk_addr = 1'b1;
            if (stopped) begin
                en = 5'd0; ep = 1'b0; ed = 1'b0; ea = '0;
                post++;
            end else if (idx >= exp_q.size()) begin
                en = 5'd0; ep = 1'b0; ed = 1'b0; ea = '0; chk_addr = 1'b0;
                post++;
            end else begin
                it = exp_q[idx];
                en = it.note; ep = it.playing; ed = it.done; ea = it.addr;
                if (it.timed && pause) en = 5'd0;
                else idx++;
            end
            if (note == 5'd3) vis3++;
            total++;
            if (note !== en || playing !== ep || done !== ed || (chk_addr && rom_addr !== ea)) begin
                bad++;
                $display("FAIL %s edge %0d: got note=%0d playing=%0b done=%0b addr=%0d, want note=%0d playing=%0b done=%0b addr=%0d",
                         name, e, note, playing, done, rom_addr, en, ep, ed, ea);
            end
            if (stop) stopped = 1'b1;
            if (post >= 4) finished = 1'b1;
            @(posedge clk);
            #1;
        end
        pause = 1'b0; stop = 1'b0; start = 1'b0;
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL %s timeout: song did not return to idle within the cycle budget", name);
        end
    endtask

    task automatic load_basic();
        rom_mem[0] = 8'h1B;
        rom_mem[1] = 8'h22;
        rom_mem[2] = 8'h00;
        rom_mem[3] = 8'(($urandom_range(1, 31) << 3) | $urandom_range(1, 7));
    endtask

    task automatic test_reset();
        total++;
        if (note !== 5'd0 || playing !== 1'b0 || done !== 1'b0 || rom_addr !== '0) begin
            bad++;
            $display("FAIL reset: got note=%0d playing=%0b done=%0b addr=%0d, want all 0",
                     note, playing, done, rom_addr);
        end
    endtask

    task automatic test_basic_song();
        int v;
        load_basic();
        run_song("basic", -1, 0, -1, -1, v);
        total++;
        if (v !== 60) begin
            bad++;
            $display("FAIL basic_note3_time: got %0d cycles, want 60", v);
        end
    endtask

    task automatic test_pause();
        int v;
        load_basic();
        run_song("pause_mid_note", 20, 25, -1, -1, v);
        total++;
        if (v !== 60) begin
            bad++;
            $display("FAIL pause_note3_time: got %0d cycles, want 60", v);
        end
        run_song("pause_untimed", 70, 6, -1, -1, v);
    endtask

    task automatic test_stop();
        int v;
        load_basic();
        run_song("stop_mid_play", -1, 0, 30, -1, v);
    endtask

    task automatic test_start_stop_same();
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (playing !== 1'b0 || note !== 5'd0 || done !== 1'b0) begin
                bad++;
                $display("FAIL start_stop_same cycle %0d: got playing=%0b note=%0d done=%0b, want 0 0 0",
                         i, playing, note, done);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int v;
        load_basic();
        run_song("restart_ignored", -1, 0, -1, 40, v);
        run_song("restart_in_gap", -1, 0, -1, 66, v);
    endtask

    task automatic test_no_marker();
        int v;
        for (int i = 0; i < ENTRIES; i++) rom_mem[i] = 8'(($urandom_range(0, 31) << 3) | 1);
        run_song("no_marker", -1, 0, -1, -1, v);
    endtask

    task automatic test_random();
        int v;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < ENTRIES; i++) rom_mem[i] = 8'($urandom_range(0, 255));
            rom_mem[0][2:0] = 3'($urandom_range(1, 7));
            run_song("random", $urandom_range(0, 150), $urandom_range(0, 40), -1, -1, v);
        end
    endtask

    task automatic test_reset_mid_gap();
        int v;
        load_basic();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (65) @(posedge clk);
        #1;
        total++;
        if (playing !== 1'b1 || note !== 5'd0) begin
            bad++;
            $display("FAIL in_gap_before_reset: got playing=%0b note=%0d, want 1 0", playing, note);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (note !== 5'd0 || playing !== 1'b0 || done !== 1'b0 || rom_addr !== '0) begin
            bad++;
            $display("FAIL async_reset_mid_gap: got note=%0d playing=%0b done=%0b addr=%0d, want all 0",
                     note, playing, done, rom_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_song("replay_after_reset", -1, 0, -1, -1, v);
        total++;
        if (v !== 60) begin
            bad++;
            $display("FAIL replay_note3_time: got %0d cycles, want 60", v);
        end
    endtask

    initial begin
        for (int i = 0; i < ENTRIES; i++) rom_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_song();
        test_pause();
        test_stop();
        test_start_stop_same();
        test_restart_ignored();
        test_no_marker();
        test_random();
        test_reset_mid_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
